// File: rtl/nexys_starship_repair_bank_if.sv
// -----------------------------------------------------------------------------
// nexys_starship_repair_bank_if
// Bundles every non-clock, non-reset signal of the repair bank.
//
// Parameters:
//   NUM_CH   number of shooter channels
//   COMBO_W  combo width in bits
//
// Signals (direction seen from the repair bank, modport slave):
//   in  timer_tick, play_flag, gameover_ctrl
//   in  break_random[NUM_CH], random_hex[COMBO_W]
//   in  repair_btn[NUM_CH], hex_combo[COMBO_W]
//   out q_Init, q_Run
//   out ch_broken[NUM_CH], ch_locked[NUM_CH], ch_combo[NUM_CH*COMBO_W]
//   out repair_done[NUM_CH], broken_count, all_broken, fail_req
//   out dbg_glb_state, dbg_ch_state (3 bits per channel, channel i at [i*3 +: 3])
//
// Handshake: there is no valid/ready pairing. Every input is sampled on each
// rising Clk edge; timer_tick and repair_btn are single-cycle pulses that count
// as one event in the cycle they are high. repair_done is a single-cycle pulse.
// -----------------------------------------------------------------------------
interface nexys_starship_repair_bank_if #(
  parameter int NUM_CH  = 4,
  parameter int COMBO_W = 4
);
  localparam int BCNT_W = $clog2(NUM_CH + 1);

  logic                      timer_tick;
  logic                      play_flag;
  logic                      gameover_ctrl;
  logic [NUM_CH-1:0]         break_random;
  logic [COMBO_W-1:0]        random_hex;
  logic [NUM_CH-1:0]         repair_btn;
  logic [COMBO_W-1:0]        hex_combo;

  logic                      q_Init;
  logic                      q_Run;
  logic [NUM_CH-1:0]         ch_broken;
  logic [NUM_CH-1:0]         ch_locked;
  logic [NUM_CH*COMBO_W-1:0] ch_combo;
  logic [NUM_CH-1:0]         repair_done;
  logic [BCNT_W-1:0]         broken_count;
  logic                      all_broken;
  logic                      fail_req;

  logic                      dbg_glb_state;
  logic [NUM_CH*3-1:0]       dbg_ch_state;

  modport master (
    output timer_tick, play_flag, gameover_ctrl, break_random, random_hex,
           repair_btn, hex_combo,
    input  q_Init, q_Run, ch_broken, ch_locked, ch_combo, repair_done,
           broken_count, all_broken, fail_req, dbg_glb_state, dbg_ch_state
  );

  modport slave (
    input  timer_tick, play_flag, gameover_ctrl, break_random, random_hex,
           repair_btn, hex_combo,
    output q_Init, q_Run, ch_broken, ch_locked, ch_combo, repair_done,
           broken_count, all_broken, fail_req, dbg_glb_state, dbg_ch_state
  );
endinterface

// File: rtl/nexys_starship_repair_bank.sv
// -----------------------------------------------------------------------------
// nexys_starship_repair_bank
// Multi-channel shooter repair engine. NUM_CH shooters share one hex keypad;
// each arms after ARM_DELAY ticks, breaks on break_random, and is repaired by
// entering its combo and pressing its own repair button. A wrong combo locks
// the channel out for LOCKOUT_TICKS ticks.
//
// Ports:
//   Clk      system clock
//   Reset_n  asynchronous active-low reset
//   bus      nexys_starship_repair_bank_if.slave (all game-side signals)
//
// Optional feature: define NEXYS_REPAIR_TIMEOUT_EN to add per-channel timeout
// counters (ticks spent in BROKEN/LOCKOUT) that raise a sticky fail_req at
// TIMEOUT_TICKS. Without it fail_req is tied low.
// -----------------------------------------------------------------------------
module nexys_starship_repair_bank #(
  parameter int NUM_CH        = 4,
  parameter int COMBO_W       = 4,
  parameter int ARM_DELAY     = 1,
  parameter int LOCKOUT_TICKS = 3,
  parameter int TIMEOUT_TICKS = 30
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  nexys_starship_repair_bank_if.slave bus
);
  localparam int CNT_MAX = (ARM_DELAY > LOCKOUT_TICKS) ? ARM_DELAY : LOCKOUT_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BCNT_W  = $clog2(NUM_CH + 1);

  localparam logic [0:0] G_INIT = 1'b0;
  localparam logic [0:0] G_RUN  = 1'b1;

  localparam logic [2:0] CH_IDLE    = 3'd0;
  localparam logic [2:0] CH_ARMING  = 3'd1;
  localparam logic [2:0] CH_ARMED   = 3'd2;
  localparam logic [2:0] CH_BROKEN  = 3'd3;
  localparam logic [2:0] CH_LOCKOUT = 3'd4;

  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $error("NUM_CH must be in 1..8");
  end
  if (LOCKOUT_TICKS < 1 || TIMEOUT_TICKS < 1) begin : g_bad_ticks
    $error("LOCKOUT_TICKS and TIMEOUT_TICKS must be at least 1");
  end

  logic [0:0]         glb_q, glb_nxt;
  logic [2:0]         st_q     [NUM_CH];
  logic [2:0]         st_nxt   [NUM_CH];
  logic [CNT_W-1:0]   cnt_q    [NUM_CH];
  logic [CNT_W-1:0]   cnt_nxt  [NUM_CH];
  logic [COMBO_W-1:0] combo_q  [NUM_CH];
  logic [COMBO_W-1:0] combo_nxt[NUM_CH];
  logic [NUM_CH-1:0]  done_nxt;
  logic [NUM_CH-1:0]  broken_q, locked_q, done_q;
  logic               abort;

  // gameover in RUN wipes every channel on the same edge, ahead of any
  // channel event in that cycle.
  assign abort = (glb_q == G_RUN) && bus.gameover_ctrl;

  always_comb begin
    glb_nxt  = glb_q;
    done_nxt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      st_nxt[i]    = st_q[i];
      cnt_nxt[i]   = cnt_q[i];
      combo_nxt[i] = combo_q[i];
    end

    if (glb_q == G_INIT) begin
      if (bus.play_flag) glb_nxt = G_RUN;
    end else if (abort) begin
      glb_nxt = G_INIT;
      for (int i = 0; i < NUM_CH; i++) begin
        st_nxt[i]    = CH_IDLE;
        cnt_nxt[i]   = '0;
        combo_nxt[i] = '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        case (st_q[i])
          CH_IDLE: begin
            st_nxt[i]  = CH_ARMING;
            cnt_nxt[i] = '0;
          end
          CH_ARMING: begin
            // Terminal check first so the counter saturates instead of wrapping.
            if (cnt_q[i] == CNT_W'(ARM_DELAY)) st_nxt[i] = CH_ARMED;
            else if (bus.timer_tick)           cnt_nxt[i] = cnt_q[i] + CNT_W'(1);
          end
          CH_ARMED: begin
            if (bus.break_random[i]) begin
              st_nxt[i]    = CH_BROKEN;
              combo_nxt[i] = bus.random_hex + COMBO_W'(i);
            end
          end
          CH_BROKEN: begin
            // A button in the same cycle as a tick wins: the counter restarts.
            if (bus.repair_btn[i]) begin
              cnt_nxt[i] = '0;
              if (bus.hex_combo == combo_q[i]) begin
                st_nxt[i]   = CH_ARMING;
                done_nxt[i] = 1'b1;
              end else begin
                st_nxt[i] = CH_LOCKOUT;
              end
            end
          end
          CH_LOCKOUT: begin
            if (cnt_q[i] == CNT_W'(LOCKOUT_TICKS)) st_nxt[i] = CH_BROKEN;
            else if (bus.timer_tick)               cnt_nxt[i] = cnt_q[i] + CNT_W'(1);
          end
          default: begin
            st_nxt[i]  = CH_IDLE;
            cnt_nxt[i] = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      glb_q    <= G_INIT;
      broken_q <= '0;
      locked_q <= '0;
      done_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        st_q[i]    <= CH_IDLE;
        cnt_q[i]   <= '0;
        combo_q[i] <= '0;
      end
    end else begin
      glb_q  <= glb_nxt;
      done_q <= done_nxt;
      for (int i = 0; i < NUM_CH; i++) begin
        st_q[i]     <= st_nxt[i];
        cnt_q[i]    <= cnt_nxt[i];
        combo_q[i]  <= combo_nxt[i];
        broken_q[i] <= (st_nxt[i] == CH_BROKEN) || (st_nxt[i] == CH_LOCKOUT);
        locked_q[i] <= (st_nxt[i] == CH_LOCKOUT);
      end
    end
  end

  // broken_count / all_broken decode straight from the state registers.
  logic [BCNT_W-1:0]         bcnt;
  logic [NUM_CH*COMBO_W-1:0] combo_flat;
  logic [NUM_CH*3-1:0]       st_flat;

  always_comb begin
    bcnt       = '0;
    combo_flat = '0;
    st_flat    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if ((st_q[i] == CH_BROKEN) || (st_q[i] == CH_LOCKOUT)) bcnt = bcnt + BCNT_W'(1);
      combo_flat[i*COMBO_W +: COMBO_W] = combo_q[i];
      st_flat[i*3 +: 3]                = st_q[i];
    end
  end

  assign bus.q_Init        = (glb_q == G_INIT);
  assign bus.q_Run         = (glb_q == G_RUN);
  assign bus.ch_broken     = broken_q;
  assign bus.ch_locked     = locked_q;
  assign bus.ch_combo      = combo_flat;
  assign bus.repair_done   = done_q;
  assign bus.broken_count  = bcnt;
  assign bus.all_broken    = (bcnt == BCNT_W'(NUM_CH));
  assign bus.dbg_glb_state = glb_q;
  assign bus.dbg_ch_state  = st_flat;

`ifdef NEXYS_REPAIR_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_TICKS + 1);

  logic [TMO_W-1:0] tmo_q  [NUM_CH];
  logic [TMO_W-1:0] tmo_nxt[NUM_CH];
  logic             fail_q, fail_nxt, fail_set;

  always_comb begin
    fail_set = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      tmo_nxt[i] = tmo_q[i];
      if ((glb_q == G_INIT) || abort || (st_nxt[i] == CH_ARMING)) begin
        tmo_nxt[i] = '0;
      end else if (((st_q[i] == CH_BROKEN) || (st_q[i] == CH_LOCKOUT)) &&
                   bus.timer_tick && (tmo_q[i] != TMO_W'(TIMEOUT_TICKS))) begin
        tmo_nxt[i] = tmo_q[i] + TMO_W'(1);
      end
      if (tmo_nxt[i] == TMO_W'(TIMEOUT_TICKS)) fail_set = 1'b1;
    end
    // Sticky until the bank returns to INIT.
    fail_nxt = (glb_nxt == G_INIT) ? 1'b0 : (fail_q | fail_set);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fail_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) tmo_q[i] <= '0;
    end else begin
      fail_q <= fail_nxt;
      for (int i = 0; i < NUM_CH; i++) tmo_q[i] <= tmo_nxt[i];
    end
  end

  assign bus.fail_req = fail_q;
`else
  assign bus.fail_req = 1'b0;
`endif

endmodule

// File: tb/tb_nexys_starship_repair_bank.sv
module tb_nexys_starship_repair_bank;
  localparam int NUM_CH        = 4;
  localparam int COMBO_W       = 4;
  localparam int ARM_DELAY     = 1;
  localparam int LOCKOUT_TICKS = 3;
  localparam int TIMEOUT_TICKS = 30;
  localparam int OUT_W         = 35;
`ifdef NEXYS_REPAIR_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nexys_starship_repair_bank_if #(.NUM_CH(NUM_CH), .COMBO_W(COMBO_W)) bus ();

  nexys_starship_repair_bank #(
    .NUM_CH(NUM_CH), .COMBO_W(COMBO_W), .ARM_DELAY(ARM_DELAY),
    .LOCKOUT_TICKS(LOCKOUT_TICKS), .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) dut (
    .Clk    (clk),
    .Reset_n(rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- scoreboard ----------------
  logic [OUT_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [OUT_W-1:0] dut_out();
    return {bus.q_Init, bus.q_Run, bus.ch_broken, bus.ch_locked, bus.ch_combo,
            bus.repair_done, bus.broken_count, bus.all_broken, bus.fail_req};
  endfunction

  function automatic logic [OUT_W-1:0] mk(input logic run, input logic [3:0] brk,
      input logic [3:0] lck, input logic [15:0] cmb, input logic [3:0] dn,
      input logic [2:0] cnt, input logic allb, input logic fail);
    return {~run, run, brk, lck, cmb, dn, cnt, allb, fail};
  endfunction

  localparam logic [OUT_W-1:0] RESET_EXP = {1'b1, 34'b0};

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic play, input logic tick, input logic gov,
      input logic [3:0] brk, input logic [3:0] rhex, input logic [3:0] btn,
      input logic [3:0] hex);
    bus.play_flag     = play;
    bus.timer_tick    = tick;
    bus.gameover_ctrl = gov;
    bus.break_random  = brk;
    bus.random_hex    = rhex;
    bus.repair_btn    = btn;
    bus.hex_combo     = hex;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // play, one tick -> all channels ARMED
  task automatic start_and_arm();
    set_in(1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0); step();
    set_in(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0); step();
    set_in(0, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0); step();
    set_in(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0); step();
  endtask

  // ---------------- reference model ----------------
  // Channel modes: 0 idle, 1 counting down to armed, 2 armed, 3 broken, 4 locked out.
  int               m_mode [NUM_CH];
  int               m_ticks[NUM_CH];
  int               m_tmo  [NUM_CH];
  logic [3:0]       m_combo[NUM_CH];
  bit               m_run, m_fail;
  logic [3:0]       m_done;

  task automatic model_reset();
    m_run = 0; m_fail = 0; m_done = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_mode[i] = 0; m_ticks[i] = 0; m_tmo[i] = 0; m_combo[i] = '0;
    end
  endtask

  task automatic model_step(input logic play, input logic tick, input logic gov,
      input logic [3:0] brk, input logic [3:0] rhex, input logic [3:0] btn,
      input logic [3:0] hex);
    m_done = '0;
    if (!m_run) begin
      if (play) m_run = 1;
    end else if (gov) begin
      model_reset();
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        int prev;
        prev = m_mode[i];
        if (prev == 0) begin
          m_mode[i] = 1; m_ticks[i] = 0;
        end else if (prev == 1) begin
          if (m_ticks[i] >= ARM_DELAY) m_mode[i] = 2;
          else if (tick) m_ticks[i]++;
        end else if (prev == 2) begin
          if (brk[i]) begin
            m_mode[i]  = 3;
            m_combo[i] = 4'((int'(rhex) + i) % 16);
          end
        end else if (prev == 3) begin
          if (btn[i]) begin
            m_ticks[i] = 0;
            if (hex == m_combo[i]) begin m_mode[i] = 1; m_done[i] = 1'b1; end
            else m_mode[i] = 4;
          end
        end else begin
          if (m_ticks[i] >= LOCKOUT_TICKS) m_mode[i] = 3;
          else if (tick) m_ticks[i]++;
        end
        if (m_mode[i] == 1) m_tmo[i] = 0;
        else if ((prev == 3 || prev == 4) && tick && m_tmo[i] < TIMEOUT_TICKS) m_tmo[i]++;
        if (TMO_ON && m_tmo[i] >= TIMEOUT_TICKS) m_fail = 1;
      end
    end
  endtask

  function automatic logic [OUT_W-1:0] model_pack();
    logic [3:0]  b, l;
    logic [15:0] c;
    int          n;
    b = '0; l = '0; c = '0; n = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      b[i] = (m_mode[i] == 3) || (m_mode[i] == 4);
      l[i] = (m_mode[i] == 4);
      c[i*4 +: 4] = m_combo[i];
      if (b[i]) n++;
    end
    return mk(m_run, b, l, c, m_done, 3'(n), n == NUM_CH, m_fail);
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        play, tick, gov;
    logic [3:0]  brk, rhex, btn, hex;
    logic [3:0]  e_broken, e_locked, e_done;
    logic [15:0] e_combo;
    logic [2:0]  e_count;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [OUT_W-1:0] act, exp;

    tbl[0]  = '{1,0,0, 4'h0, 4'h0, 4'h0, 4'h0,  4'h0, 4'h0, 4'h0, 16'h0000, 3'd0};
    tbl[1]  = '{0,0,0, 4'h0, 4'h0, 4'h0, 4'h0,  4'h0, 4'h0, 4'h0, 16'h0000, 3'd0};
    tbl[2]  = '{0,1,0, 4'h0, 4'h0, 4'h0, 4'h0,  4'h0, 4'h0, 4'h0, 16'h0000, 3'd0};
    tbl[3]  = '{0,0,0, 4'h0, 4'h0, 4'h0, 4'h0,  4'h0, 4'h0, 4'h0, 16'h0000, 3'd0};
    tbl[4]  = '{0,0,0, 4'h5, 4'hE, 4'h0, 4'h0,  4'h5, 4'h0, 4'h0, 16'h000E, 3'd2};
    tbl[5]  = '{0,0,0, 4'h0, 4'h0, 4'h1, 4'h3,  4'h5, 4'h1, 4'h0, 16'h000E, 3'd2};
    tbl[6]  = '{0,1,0, 4'h0, 4'h0, 4'h0, 4'h0,  4'h5, 4'h1, 4'h0, 16'h000E, 3'd2};
    tbl[7]  = '{0,1,0, 4'h0, 4'h0, 4'h1, 4'hE,  4'h5, 4'h1, 4'h0, 16'h000E, 3'd2};
    tbl[8]  = '{0,1,0, 4'h0, 4'h0, 4'h0, 4'h0,  4'h5, 4'h1, 4'h0, 16'h000E, 3'd2};
    tbl[9]  = '{0,0,0, 4'h0, 4'h0, 4'h0, 4'h0,  4'h5, 4'h0, 4'h0, 16'h000E, 3'd2};
    tbl[10] = '{0,0,0, 4'h0, 4'h0, 4'h1, 4'hE,  4'h4, 4'h0, 4'h1, 16'h000E, 3'd1};
    tbl[11] = '{0,0,0, 4'h0, 4'h0, 4'h0, 4'h0,  4'h4, 4'h0, 4'h0, 16'h000E, 3'd1};

    do_reset();
    check("reset_state", dut_out(), RESET_EXP);

    // Break / wrong combo / lockout / repair walk-through.
    for (int r = 0; r < 12; r++) begin
      set_in(tbl[r].play, tbl[r].tick, tbl[r].gov, tbl[r].brk, tbl[r].rhex,
             tbl[r].btn, tbl[r].hex);
      step();
      check($sformatf("table_row%0d", r), dut_out(),
            mk(1'b1, tbl[r].e_broken, tbl[r].e_locked, tbl[r].e_combo,
               tbl[r].e_done, tbl[r].e_count, 1'b0, 1'b0));
    end

    // All channels broken, then gameover with a simultaneous correct repair.
    set_in(0, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0); step();
    set_in(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0); step();
    set_in(0, 0, 0, 4'hB, 4'h5, 4'h0, 4'h0); step();
    check("all_broken", dut_out(), mk(1'b1, 4'hF, 4'h0, 16'h8065, 4'h0, 3'd4, 1'b1, 1'b0));
    set_in(0, 0, 1, 4'h0, 4'h0, 4'h4, 4'h0); step();
    check("gameover_wins", dut_out(), RESET_EXP);
    set_in(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0); step();
    check("init_holds", dut_out(), RESET_EXP);

    // Asynchronous reset mid-game with ch2 broken and its repair pending.
    start_and_arm();
    set_in(0, 0, 0, 4'h4, 4'h7, 4'h0, 4'h0); step();
    check("ch2_broken", dut_out(), mk(1'b1, 4'h4, 4'h0, 16'h0900, 4'h0, 3'd1, 1'b0, 1'b0));
    set_in(0, 0, 0, 4'h0, 4'h0, 4'h4, 4'h9);
    #2 rst_n = 1'b0;
    #1 check("async_reset", dut_out(), RESET_EXP);
    for (int k = 0; k < 2; k++) begin
      step();
      check($sformatf("reset_no_pulse%0d", k), dut_out(), RESET_EXP);
    end
    set_in(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
    rst_n = 1'b1;
    step();
    check("after_release", dut_out(), RESET_EXP);

    // Repair timeout on ch1.
    start_and_arm();
    set_in(0, 0, 0, 4'h2, 4'h0, 4'h0, 4'h0); step();
    check("ch1_broken", dut_out(), mk(1'b1, 4'h2, 4'h0, 16'h0010, 4'h0, 3'd1, 1'b0, 1'b0));
    set_in(0, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0);
    repeat (TIMEOUT_TICKS - 1) step();
    check("fail_before_timeout", 64'(bus.fail_req), 64'(1'b0));
    step();
    check("fail_at_timeout", 64'(bus.fail_req), 64'(TMO_ON));
    set_in(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
    repeat (3) step();
    check("fail_sticky", 64'(bus.fail_req), 64'(TMO_ON));
    set_in(0, 0, 1, 4'h0, 4'h0, 4'h0, 4'h0); step();
    check("fail_cleared", dut_out(), RESET_EXP);

    // Randomised run against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic       play, tick, gov;
      logic [3:0] brk, rhex, btn, hex;
      int         pick;
      play = ($urandom_range(0, 3) == 0);
      tick = ($urandom_range(0, 2) == 0);
      gov  = ($urandom_range(0, 149) == 0);
      rhex = 4'($urandom_range(0, 15));
      for (int i = 0; i < NUM_CH; i++) begin
        brk[i] = ($urandom_range(0, 3) == 0);
        btn[i] = ($urandom_range(0, 3) == 0);
      end
      pick = $urandom_range(0, NUM_CH - 1);
      hex  = ($urandom_range(0, 1) == 1) ? m_combo[pick] : 4'($urandom_range(0, 15));
      set_in(play, tick, gov, brk, rhex, btn, hex);
      model_step(play, tick, gov, brk, rhex, btn, hex);
      exp_q.push_back(model_pack());
      step();
      act = dut_out();
      exp = exp_q.pop_front();
      check($sformatf("random_cycle%0d", c), act, exp);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
